// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Holds the scan state encoding, the all-off segment code and the hex glyph table.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex value n.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg7_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = HEX_SEG[hex_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with inter-digit blanking, stepped by scan_clk_i edges.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned IDX_W        = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_n,
  input  logic                      scan_clk_i,
  input  logic                      enable_i,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  output logic [NUM_DIGITS-1:0]     anode_n_o,
  output logic [6:0]                seg_n_o,
  output logic                      dp_n_o,
  output logic                      frame_o,
  output logic                      overrun_o
);

  localparam int unsigned      CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic sync1_q, sync2_q, hist_q;
  logic tick;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]  anode_q, anode_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic                   frame_q, frame_d;
  logic                   ovr_q, ovr_d;

  logic [3:0]             cur_digit;
  logic                   cur_dp;
  logic [NUM_DIGITS-1:0]  anode_sel;
  logic [6:0]             dec_seg;
  logic [6:0]             seg_load;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= scan_clk_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~hist_q;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    anode_sel = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit    = digits_i[4*k +: 4];
        cur_dp       = dp_i[k];
        anode_sel[k] = 1'b0;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .hex_i   (cur_digit),
    .seg_n_o (dec_seg)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic lz_blank;

  // Digit k is blanked only when it and every more-significant digit are zero.
  always_comb begin
    lz_blank = 1'b0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        lz_blank = 1'b1;
        for (int unsigned j = k; j < NUM_DIGITS; j++) begin
          if (digits_i[4*j +: 4] != 4'h0) lz_blank = 1'b0;
        end
      end
    end
  end

  assign seg_load = lz_blank ? SEG_OFF : dec_seg;
`else
  assign seg_load = dec_seg;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    frame_d = 1'b0;
    ovr_d   = ovr_q;

    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      anode_d = '1;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          anode_d = '1;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          if (tick) begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end
        BLANK: begin
          anode_d = '1;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          if (tick) ovr_d = 1'b1;
          // Digit data is sampled only here, so it stays stable for the whole DRIVE phase.
          if (cnt_q == CNT_LAST) begin
            state_d = DRIVE;
            anode_d = anode_sel;
            seg_d   = seg_load;
            dp_d    = ~cur_dp;
            frame_d = (idx_q == '0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (tick) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            anode_d = '1;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          anode_d = '1;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      anode_q <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
    end
  end

  assign anode_n_o = anode_q;
  assign seg_n_o   = seg_q;
  assign dp_n_o    = dp_q;
  assign frame_o   = frame_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected digit frames are queued, a monitor checks each new drive.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scan_clk;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  anode_n_o;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic        frame_o;
  logic        overrun_o;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (4),
    .IDX_W        (3)
  ) dut (
    .clk_i      (clk),
    .reset_n    (reset_n),
    .scan_clk_i (scan_clk),
    .enable_i   (enable),
    .digits_i   (digits),
    .dp_i       (dp),
    .anode_n_o  (anode_n_o),
    .seg_n_o    (seg_n_o),
    .dp_n_o     (dp_n_o),
    .frame_o    (frame_o),
    .overrun_o  (overrun_o)
  );

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
    int         gap;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   frames_seen = 0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input logic f, input int g);
    exp_t e;
    e.anode = a; e.seg = s; e.dp_n = d; e.frame = f; e.gap = g;
    expq.push_back(e);
  endtask

  task automatic pulse();
    @(negedge clk) scan_clk = 1'b1;
    repeat (8) @(negedge clk);
    scan_clk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Second rising edge lands while the driver is still blanking.
  task automatic double_pulse();
    @(negedge clk) scan_clk = 1'b1;
    @(negedge clk) scan_clk = 1'b0;
    @(negedge clk) scan_clk = 1'b1;
    repeat (8) @(negedge clk);
    scan_clk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: a drive starts when the anodes leave the all-off state.
  initial begin
    int         off_cnt;
    logic [3:0] prev;
    exp_t       e;
    off_cnt = 0;
    prev    = 4'hF;
    forever begin
      @(negedge clk);
      if (frame_o) frames_seen++;
      if (anode_n_o == 4'hF) begin
        off_cnt++;
      end else if (prev == 4'hF) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drive: got anode %b expected none queued", anode_n_o);
        end else begin
          e = expq.pop_front();
          chk("anode", 32'(anode_n_o), 32'(e.anode));
          chk("seg",   32'(seg_n_o),   32'(e.seg));
          chk("dp_n",  32'(dp_n_o),    32'(e.dp_n));
          chk("frame", 32'(frame_o),   32'(e.frame));
          if (e.gap >= 0) chk("blank_gap", 32'(off_cnt), 32'(e.gap));
        end
        off_cnt = 0;
      end
      prev = anode_n_o;
    end
  end

  initial begin
    reset_n  = 1'b0;
    scan_clk = 1'b0;
    enable   = 1'b0;
    digits   = 16'h12AF;
    dp       = 4'b0100;
    repeat (3) @(negedge clk);
    chk("rst_anode",   32'(anode_n_o), 32'hF);
    chk("rst_seg",     32'(seg_n_o),   32'h7F);
    chk("rst_dp",      32'(dp_n_o),    32'h1);
    chk("rst_frame",   32'(frame_o),   32'h0);
    chk("rst_overrun", 32'(overrun_o), 32'h0);
    reset_n = 1'b1;
    @(negedge clk) enable = 1'b1;
    repeat (3) @(negedge clk);

    push(4'b1110, 7'b0001110, 1'b1, 1'b1, -1); pulse();
    push(4'b1101, 7'b0001000, 1'b1, 1'b0, 4);  pulse();
    push(4'b1011, 7'b0100100, 1'b0, 1'b0, 4);  pulse();
    push(4'b0111, 7'b1111001, 1'b1, 1'b0, 4);  pulse();
    push(4'b1110, 7'b0001110, 1'b1, 1'b1, 4);  pulse();

    chk("overrun_before", 32'(overrun_o), 32'h0);
    push(4'b1101, 7'b0001000, 1'b1, 1'b0, 4);  double_pulse();
    chk("overrun_set", 32'(overrun_o), 32'h1);
    push(4'b1011, 7'b0100100, 1'b0, 1'b0, 4);  pulse();
    chk("overrun_sticky", 32'(overrun_o), 32'h1);

    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    chk("dis_anode",   32'(anode_n_o), 32'hF);
    chk("dis_seg",     32'(seg_n_o),   32'h7F);
    chk("dis_dp",      32'(dp_n_o),    32'h1);
    chk("dis_frame",   32'(frame_o),   32'h0);
    chk("dis_overrun", 32'(overrun_o), 32'h1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    push(4'b1110, 7'b0001110, 1'b1, 1'b1, -1); pulse();

    digits = 16'h0050;
    push(4'b1101, 7'b0010010, 1'b1, 1'b0, 4);  pulse();
    push(4'b1011, LZ_SEG,     1'b0, 1'b0, 4);  pulse();
    push(4'b0111, LZ_SEG,     1'b1, 1'b0, 4);  pulse();
    push(4'b1110, 7'b1000000, 1'b1, 1'b1, 4);  pulse();

    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    chk("frame_count",   32'(frames_seen), 32'd4);

    // Asynchronous reset while digit 0 is being driven, sampled before any clock edge.
    @(negedge clk);
    chk("pre_rst_anode", 32'(anode_n_o), 32'b1110);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_anode",   32'(anode_n_o), 32'hF);
    chk("arst_seg",     32'(seg_n_o),   32'h7F);
    chk("arst_dp",      32'(dp_n_o),    32'h1);
    chk("arst_frame",   32'(frame_o),   32'h0);
    chk("arst_overrun", 32'(overrun_o), 32'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
